// File: rtl/fraise_wl_pkg.sv
// rtl/fraise_wl_pkg.sv - shared types and flag decode for the CWL_left sequencer
package fraise_wl_pkg;

   typedef enum logic [1:0] {
      OP_PROG  = 2'd0,
      OP_READ1 = 2'd1,
      OP_READ8 = 2'd2,
      OP_INFER = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      PULSE = 3'd2,
      HOLD  = 3'd3,
      DONE  = 3'd4
   } wl_state_e;

   typedef struct packed {
      logic inference;
      logic read_1;
      logic read_8;
   } wl_flags_t;

   // Mode flags are one-hot-or-zero; programming drives none of them.
   function automatic wl_flags_t decode_flags(op_e op);
      wl_flags_t f;
      f           = '0;
      f.inference = (op == OP_INFER);
      f.read_1    = (op == OP_READ1);
      f.read_8    = (op == OP_READ8);
      return f;
   endfunction

endpackage

// File: rtl/wl_phase_timer.sv
// rtl/wl_phase_timer.sv - loadable phase down-counter with zero flag
module wl_phase_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic             zero_o
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_cnt <= '0;
      end else if (load_i) begin
         r_cnt <= load_val_i;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign zero_o = (r_cnt == '0);

endmodule

// File: rtl/cwl_left_sequencer.sv
// rtl/cwl_left_sequencer.sv - setup/pulse/hold sequencer for the left RRAM row decoder
// Optional CWL_PULSE_PROG_EN adds a per-command pulse width input.
module cwl_left_sequencer
   import fraise_wl_pkg::*;
#(
   parameter int Narray    = 2,
   parameter int SETUP_CYC = 2,
   parameter int PULSE_CYC = 4,
   parameter int HOLD_CYC  = 2,
   parameter int CNT_W     = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic [1:0]        cmd_op_i,
   input  logic [Narray-1:0] cmd_row_i,
   input  logic              abort_i,
`ifdef CWL_PULSE_PROG_EN
   input  logic [CNT_W-1:0]  pulse_cyc_i,
`endif
   output logic              CWL_left_o,
   output logic              inference_o,
   output logic              read_1_o,
   output logic              read_8_o,
   output logic [Narray-1:0] adr_full_row_o,
   output logic              busy_o,
   output logic              done_o
);

   localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

   wl_state_e         r_state, w_state_nxt;
   wl_flags_t         r_flags;
   logic [Narray-1:0] r_adr;
   logic              r_cwl, r_busy, r_ready, r_done;
   logic              w_accept, w_ld, w_zero;
   logic [CNT_W-1:0]  w_ld_val, w_pulse_ld;
   op_e               w_op;

   assign w_op = op_e'(cmd_op_i);

`ifdef CWL_PULSE_PROG_EN
   logic [CNT_W-1:0] r_pulse_ld;

   // A requested width of 0 still yields a single-cycle pulse.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_pulse_ld <= CNT_W'(PULSE_CYC - 1);
      end else if (w_accept) begin
         r_pulse_ld <= (pulse_cyc_i == '0) ? '0 : pulse_cyc_i - 1'b1;
      end
   end

   assign w_pulse_ld = r_pulse_ld;
`else
   assign w_pulse_ld = CNT_W'(PULSE_CYC - 1);
`endif

   wl_phase_timer #(.CNT_W(CNT_W)) u_timer (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (w_ld),
      .load_val_i (w_ld_val),
      .zero_o     (w_zero)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_ld        = 1'b0;
      w_ld_val    = '0;
      case (r_state)
         IDLE: begin
            if (cmd_valid_i && !abort_i) begin
               w_accept    = 1'b1;
               w_state_nxt = SETUP;
               w_ld        = 1'b1;
               w_ld_val    = SETUP_LD;
            end
         end
         SETUP: begin
            if (abort_i) begin
               w_state_nxt = IDLE;
            end else if (w_zero) begin
               w_ld = 1'b1;
               if (r_flags.inference) begin
                  w_state_nxt = HOLD;
                  w_ld_val    = HOLD_LD;
               end else begin
                  w_state_nxt = PULSE;
                  w_ld_val    = w_pulse_ld;
               end
            end
         end
         PULSE: begin
            if (abort_i) begin
               w_state_nxt = IDLE;
            end else if (w_zero) begin
               w_state_nxt = HOLD;
               w_ld        = 1'b1;
               w_ld_val    = HOLD_LD;
            end
         end
         HOLD: begin
            if (abort_i) begin
               w_state_nxt = IDLE;
            end else if (w_zero) begin
               w_state_nxt = DONE;
            end
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Outputs are registered from the next state so the decoder sees them aligned with the phase.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state <= IDLE;
         r_flags <= '0;
         r_adr   <= '0;
         r_cwl   <= 1'b0;
         r_busy  <= 1'b0;
         r_ready <= 1'b1;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cwl   <= (w_state_nxt == PULSE);
         r_busy  <= (w_state_nxt != IDLE);
         r_ready <= (w_state_nxt == IDLE);
         r_done  <= (w_state_nxt == DONE);
         if (w_accept) begin
            r_flags <= decode_flags(w_op);
            r_adr   <= (w_op == OP_READ8) ? '0 : cmd_row_i;
         end else if (w_state_nxt == IDLE || w_state_nxt == DONE) begin
            r_flags <= '0;
            r_adr   <= '0;
         end
      end
   end

   assign cmd_ready_o    = r_ready;
   assign busy_o         = r_busy;
   assign done_o         = r_done;
   assign CWL_left_o     = r_cwl;
   assign inference_o    = r_flags.inference;
   assign read_1_o       = r_flags.read_1;
   assign read_8_o       = r_flags.read_8;
   assign adr_full_row_o = r_adr;

endmodule

// File: tb/tb_cwl_left_sequencer.sv
// tb/tb_cwl_left_sequencer.sv - self-checking bench for cwl_left_sequencer
module tb_cwl_left_sequencer;

   localparam int S_CYC = 2;
   localparam int P_CYC = 4;
   localparam int H_CYC = 2;

   typedef struct packed {
      logic       cwl;
      logic       inf;
      logic       r1;
      logic       r8;
      logic [1:0] adr;
      logic       busy;
      logic       ready;
      logic       done;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [1:0] cmd_row;
   logic       abort;
   logic       cwl, inf, r1, r8, busy, done;
   logic [1:0] adr;
`ifdef CWL_PULSE_PROG_EN
   logic [7:0] pulse_cyc;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   cwl_left_sequencer #(
      .Narray(2), .SETUP_CYC(S_CYC), .PULSE_CYC(P_CYC), .HOLD_CYC(H_CYC), .CNT_W(8)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .cmd_valid_i    (cmd_valid),
      .cmd_ready_o    (cmd_ready),
      .cmd_op_i       (cmd_op),
      .cmd_row_i      (cmd_row),
      .abort_i        (abort),
`ifdef CWL_PULSE_PROG_EN
      .pulse_cyc_i    (pulse_cyc),
`endif
      .CWL_left_o     (cwl),
      .inference_o    (inf),
      .read_1_o       (r1),
      .read_8_o       (r8),
      .adr_full_row_o (adr),
      .busy_o         (busy),
      .done_o         (done)
   );

   function automatic exp_t observed();
      return '{cwl, inf, r1, r8, adr, busy, cmd_ready, done};
   endfunction

   // Expected outputs t cycles after the accept cycle, straight from the phase lengths.
   function automatic exp_t model(int op, int row, int plen, int ab, int t);
      exp_t m;
      int   p, e;
      p       = (op == 3) ? 0 : plen;
      e       = S_CYC + p + H_CYC;
      m       = '0;
      m.ready = 1'b1;
      if (ab != 0 && t > ab) return m;
      if (t >= 1 && t <= e) begin
         m.ready = 1'b0;
         m.busy  = 1'b1;
         m.cwl   = (t > S_CYC) && (t <= S_CYC + p);
         m.inf   = (op == 3);
         m.r1    = (op == 1);
         m.r8    = (op == 2);
         m.adr   = (op == 2) ? 2'd0 : 2'(row);
      end else if (t == e + 1) begin
         m.ready = 1'b0;
         m.busy  = 1'b1;
         m.done  = 1'b1;
      end
      return m;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic run_cmd(input int op, input int row, input int pcyc, input int ab, input bit noise);
      int plen, e;
`ifdef CWL_PULSE_PROG_EN
      plen = (pcyc == 0) ? 1 : pcyc;
`else
      plen = P_CYC;
`endif
      e = S_CYC + ((op == 3) ? 0 : plen) + H_CYC;
      @(negedge clk);
      chk("ready_before_cmd", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_op    = 2'(op);
      cmd_row   = 2'(row);
`ifdef CWL_PULSE_PROG_EN
      pulse_cyc = 8'(pcyc);
`endif
      for (int t = 1; t <= e + 3; t++) begin
         @(posedge clk);
         #1;
         abort     = (t == ab);
         cmd_valid = noise && (t <= e + 1) && (ab == 0 || t <= ab) && ($urandom_range(1) == 1);
         cmd_op    = 2'($urandom_range(3));
         cmd_row   = 2'($urandom_range(3));
`ifdef CWL_PULSE_PROG_EN
         pulse_cyc = 8'($urandom_range(9));
`endif
         @(negedge clk);
         chk($sformatf("op%0d_row%0d_ab%0d_t%0d", op, row, ab, t),
             32'(observed()), 32'(model(op, row, plen, ab, t)));
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      abort     = 1'b0;
   endtask

   initial begin
      int op, row, pc, ab, e;
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 2'd0;
      cmd_row   = 2'd0;
      abort     = 1'b0;
`ifdef CWL_PULSE_PROG_EN
      pulse_cyc = 8'd0;
`endif
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Idle after reset: only ready high, no done strobe.
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("idle_after_reset", 32'(observed()), 32'(model(0, 0, P_CYC, 0, 0)));
      end

      run_cmd(0, 2, P_CYC, 0, 1'b0);
      run_cmd(2, 3, P_CYC, 0, 1'b0);
      run_cmd(3, 1, P_CYC, 0, 1'b0);
      run_cmd(1, 1, P_CYC, S_CYC + 2, 1'b0);
      run_cmd(0, 1, 0, 0, 1'b1);
      run_cmd(1, 2, 7, 0, 1'b1);

      // Abort coinciding with a request in IDLE drops the command.
      @(negedge clk);
      cmd_valid = 1'b1;
      abort     = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      abort     = 1'b0;
      @(negedge clk);
      chk("abort_wins_accept", 32'(observed()), 32'(model(0, 0, P_CYC, 0, 0)));

      // Reset during the pulse drops CWL_left on the next edge.
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = 2'd0;
      cmd_row   = 2'd3;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("cwl_before_reset", 32'(cwl), 32'd1);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("reset_mid_op", 32'(observed()), 32'(model(0, 0, P_CYC, 0, 0)));
      rst_n = 1'b1;

      for (int n = 0; n < 25; n++) begin
         op  = int'($urandom_range(3));
         row = int'($urandom_range(3));
         pc  = int'($urandom_range(6));
`ifdef CWL_PULSE_PROG_EN
         e   = S_CYC + ((op == 3) ? 0 : ((pc == 0) ? 1 : pc)) + H_CYC;
`else
         e   = S_CYC + ((op == 3) ? 0 : P_CYC) + H_CYC;
`endif
         ab  = ($urandom_range(3) == 0) ? int'($urandom_range(e, 1)) : 0;
         run_cmd(op, row, pc, ab, 1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
